// File: rtl/regfile_mp_clr.sv
// ============================================================================
//  Module      : regfile_mp_clr
//  Description : Parametrised multi-read-port register file with same-cycle
//                write-to-read bypass, optional hardwired-zero register 0
//                and a clear sequencer that zeroes the array after reset or
//                on request (BUSY stalls the pipeline while it runs).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_mp_clr #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NREAD    = 3,
  parameter int ZERO_REG = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    we3,
  input  logic [ADDR_W-1:0]       wa3,
  input  logic [DATA_W-1:0]       wd3,
  input  logic [NREAD*ADDR_W-1:0] ra,
  output logic [NREAD*DATA_W-1:0] rd,
  input  logic                    clr,
  output logic                    busy
);

  localparam int               DEPTH    = 1 << ADDR_W;
  localparam bit               HAS_ZERO = (ZERO_REG != 0);
  localparam logic [ADDR_W-1:0] LAST_PTR = '1;

  typedef enum logic [0:0] {
    S_CLEAR = 1'b0,
    S_IDLE  = 1'b1
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [ADDR_W-1:0]   ptr;
  logic [ADDR_W-1:0]   ptr_nxt;
  logic                busy_nxt;
  logic                wr_en;
  logic [DATA_W-1:0]   rf [DEPTH];

  // A write is only honoured outside the sweep and never to a hardwired r0;
  // writes presented while busy are simply lost.
  assign wr_en = we3 && !busy && !(HAS_ZERO && (wa3 == '0));

  // Sequencer state register; reset parks it at the start of a fresh sweep.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_CLEAR;
      ptr   <= '0;
      busy  <= 1'b1;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      busy  <= busy_nxt;
    end
  end

  // Sequencer next state: sweep one entry per cycle, CLR restarts from 0.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    busy_nxt  = busy;
    case (state)
      S_CLEAR: begin
        if (clr) begin
          ptr_nxt  = '0;
          busy_nxt = 1'b1;
        end else if (ptr == LAST_PTR) begin
          state_nxt = S_IDLE;
          ptr_nxt   = '0;
          busy_nxt  = 1'b0;
        end else begin
          ptr_nxt = ptr + ADDR_W'(1);
        end
      end
      S_IDLE: begin
        if (clr) begin
          state_nxt = S_CLEAR;
          ptr_nxt   = '0;
          busy_nxt  = 1'b1;
        end
      end
      default: begin
        state_nxt = S_CLEAR;
        ptr_nxt   = '0;
        busy_nxt  = 1'b1;
      end
    endcase
  end

  // Storage: the sweep owns the array while clearing, otherwise the WB port.
  // Contents are deliberately not reset; BUSY hides them until swept.
  always_ff @(posedge clk) begin
    if (state == S_CLEAR) begin
      rf[ptr] <= '0;
    end else if (wr_en) begin
      rf[wa3] <= wd3;
    end
  end

  // Independent combinational read ports with zero-reg, busy and bypass.
  for (genvar i = 0; i < NREAD; i++) begin : g_rd
    logic [ADDR_W-1:0] ra_i;
    logic [DATA_W-1:0] rd_i;

    assign ra_i = ra[i*ADDR_W +: ADDR_W];
    assign rd[i*DATA_W +: DATA_W] = rd_i;

    // Priority: hardwired zero, then sweep masking, then bypass, then array.
    always_comb begin
      rd_i = rf[ra_i];
      if (HAS_ZERO && (ra_i == '0)) begin
        rd_i = '0;
      end else if (busy) begin
        rd_i = '0;
      end else if (wr_en && (wa3 == ra_i)) begin
        rd_i = wd3;
      end
    end
  end

endmodule

`default_nettype wire
